dsp_sub_pair_sched: RTL

DSP_SUB_PAIR_SCHED -- requirements
Module: dsp_sub_pair_sched

---
 rtl/dsp_sub_pair_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dsp_sub_pair_sched.sv
// dsp_sub_pair_sched: pairs consecutive scalar subtract requests into the two
// lanes of an external SIMD subtractor, fires both lanes in one evaluation and
// replays the lane results as a scalar stream in acceptance order.
// Optional feature macro: DSP_SUB_PAIR_TIMEOUT_EN -- when defined, a lone
// operand waiting in HALF is flushed as a single-lane issue after `timeout`
// HALF cycles; when undefined, HALF waits indefinitely for a partner.
module dsp_sub_pair_sched #(
  parameter int unsigned width   = 24,
  parameter int unsigned timeout = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  output logic [width-1:0] dsp_a0,
  output logic [width-1:0] dsp_b0,
  output logic [width-1:0] dsp_a1,
  output logic [width-1:0] dsp_b1,
  input  logic [width-1:0] dsp_y0,
  input  logic [width-1:0] dsp_y1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_y
);

  // Reject illegal configurations at elaboration time.
  if (width == 0 || width > 24) begin : g_bad_width
    $error("dsp_sub_pair_sched: width must be in 1..24");
  end
  if (timeout == 0 || timeout > 255) begin : g_bad_timeout
    $error("dsp_sub_pair_sched: timeout must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_EMPTY,
    S_HALF,
    S_FIRE,
    S_DRAIN0,
    S_DRAIN1
  } state_t;

  state_t           state_q, state_d;
  logic [width-1:0] a0_q, a0_d, b0_q, b0_d;
  logic [width-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [width-1:0] r0_q, r0_d, r1_q, r1_d;
  logic             pair_q, pair_d;
  logic             accept;

`ifdef DSP_SUB_PAIR_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(timeout - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign in_ready = ~reset & ((state_q == S_EMPTY) | (state_q == S_HALF));
  assign accept   = in_valid & in_ready;

  // Next-state logic: operand capture, pairing/flush decision, result capture.
  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    b0_d    = b0_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    pair_d  = pair_q;
`ifdef DSP_SUB_PAIR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          a0_d    = in_a;
          b0_d    = in_b;
`ifdef DSP_SUB_PAIR_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = S_HALF;
        end
      end
      S_HALF: begin
        // A partner arriving in the flush cycle wins over the flush.
        if (accept) begin
          a1_d    = in_a;
          b1_d    = in_b;
          pair_d  = 1'b1;
          state_d = S_FIRE;
        end
`ifdef DSP_SUB_PAIR_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          a1_d    = '0;
          b1_d    = '0;
          pair_d  = 1'b0;
          state_d = S_FIRE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      S_FIRE: begin
        r0_d    = dsp_y0;
        r1_d    = dsp_y1;
        state_d = S_DRAIN0;
      end
      S_DRAIN0: begin
        if (out_ready) begin
          state_d = pair_q ? S_DRAIN1 : S_EMPTY;
        end
      end
      S_DRAIN1: begin
        if (out_ready) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      pair_q  <= 1'b0;
`ifdef DSP_SUB_PAIR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      pair_q  <= pair_d;
`ifdef DSP_SUB_PAIR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Lane operands drive the subtractor directly; forced to zero while in reset.
  assign dsp_a0 = reset ? '0 : a0_q;
  assign dsp_b0 = reset ? '0 : b0_q;
  assign dsp_a1 = reset ? '0 : a1_q;
  assign dsp_b1 = reset ? '0 : b1_q;

  assign out_valid = ~reset & ((state_q == S_DRAIN0) | (state_q == S_DRAIN1));

  // Scalar result mux; zero whenever no result is presented.
  always_comb begin
    out_y = '0;
    if (!reset) begin
      case (state_q)
        S_DRAIN0: out_y = r0_q;
        S_DRAIN1: out_y = r1_q;
        default:  out_y = '0;
      endcase
    end
  end

endmodule
